// File: rtl/cam_motion.sv
// Per-frame camera X integrator with edge saturation and dwell.
// Optional CAM_MOTION_ACCEL_EN: camS ramps by one per MOVE tick instead of tracking speed_in.
module cam_motion #(
  parameter int unsigned X_MIN        = 10,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned X_INIT       = 40,
  parameter int unsigned DWELL_FRAMES = 4,
  parameter int unsigned S_MAX        = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [9:0] speed_in,
  input  logic [1:0] direction_cam,
  output logic [9:0] camX,
  output logic [9:0] camS,
  output logic       moving,
  output logic       at_edge,
  output logic       frame_tick
);

  localparam int unsigned XW = 10;
  localparam int unsigned AW = 11;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

  state_t        r_state;
  logic [XW-1:0] r_camX;
  logic [XW-1:0] r_camS;
  logic [CW-1:0] r_dwell_cnt;
  logic          r_moving;
  logic          r_s1, r_s2, r_s3;
`ifdef CAM_MOTION_ACCEL_EN
  logic          r_dir;
  logic [XW-1:0] w_base;
  logic [XW-1:0] w_inc;
`endif

  logic          w_tick;
  logic [XW-1:0] w_lim;
  logic [XW-1:0] w_step;
  logic [AW-1:0] w_sum;
  logic [XW-1:0] w_left;
  logic [XW-1:0] w_right;
  logic [XW-1:0] w_next;
  logic          w_hit_edge;

  assign w_tick     = r_s2 & ~r_s3;
  assign frame_tick = w_tick;
  assign camX       = r_camX;
  assign camS       = r_camS;
  assign moving     = r_moving;
  assign at_edge    = (r_camX == XW'(X_MIN)) || (r_camX == XW'(X_MAX));

  // Step size and saturating candidate position; 11-bit sum keeps right moves from wrapping.
  always_comb begin
    w_lim = speed_in;
    if (speed_in == '0)
      w_lim = XW'(1);
    else if (speed_in > XW'(S_MAX))
      w_lim = XW'(S_MAX);
`ifdef CAM_MOTION_ACCEL_EN
    w_base = (direction_cam[0] != r_dir) ? XW'(1) : r_camS;
    w_inc  = (w_base >= w_lim) ? w_lim : w_base + XW'(1);
    w_step = w_base;
`else
    w_step = w_lim;
`endif
    w_sum   = {1'b0, r_camX} + {1'b0, w_step};
    w_left  = ({1'b0, r_camX} < AW'(X_MIN) + {1'b0, w_step}) ? XW'(X_MIN) : r_camX - w_step;
    w_right = (w_sum > AW'(X_MAX)) ? XW'(X_MAX) : w_sum[XW-1:0];
    w_next  = direction_cam[0] ? w_right : w_left;
    w_hit_edge = (w_next == XW'(X_MIN)) || (w_next == XW'(X_MAX));
  end

  // Synchroniser plus FSM; everything past the sync flops only advances on a frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_state     <= IDLE;
      r_camX      <= XW'(X_INIT);
      r_camS      <= XW'(1);
      r_dwell_cnt <= '0;
      r_moving    <= 1'b0;
`ifdef CAM_MOTION_ACCEL_EN
      r_dir       <= 1'b0;
`endif
    end else begin
      r_s1 <= frame_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_tick) begin
`ifndef CAM_MOTION_ACCEL_EN
        r_camS <= w_lim;
`endif
        case (r_state)
          IDLE: begin
            r_moving <= 1'b0;
            if (enable) r_state <= MOVE;
          end
          MOVE: begin
            if (!enable) begin
              r_state  <= IDLE;
              r_moving <= 1'b0;
`ifdef CAM_MOTION_ACCEL_EN
              r_camS   <= XW'(1);
`endif
            end else if (direction_cam[1]) begin
              r_moving <= 1'b0;
            end else begin
              r_camX   <= w_next;
              r_moving <= (w_next != r_camX);
`ifdef CAM_MOTION_ACCEL_EN
              r_camS   <= w_inc;
              r_dir    <= direction_cam[0];
`endif
              if (w_hit_edge) begin
                r_state     <= DWELL;
                r_dwell_cnt <= CW'(DWELL_FRAMES - 1);
              end
            end
          end
          DWELL: begin
            r_moving <= 1'b0;
            if (!enable) begin
              r_state <= IDLE;
`ifdef CAM_MOTION_ACCEL_EN
              r_camS  <= XW'(1);
`endif
            end else if (r_dwell_cnt == '0) begin
              r_state <= MOVE;
`ifdef CAM_MOTION_ACCEL_EN
              r_camS  <= XW'(1);
`endif
            end else begin
              r_dwell_cnt <= r_dwell_cnt - CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_motion.sv
// Self-checking bench for cam_motion (default build) against a frame-level reference model.
`timescale 1ns/1ps
module tb_cam_motion;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       enable;
  logic [9:0] speed_in;
  logic [1:0] direction_cam;
  logic [9:0] camX;
  logic [9:0] camS;
  logic       moving;
  logic       at_edge;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;
  int nfr      = 0;

  // Reference model: mode 0 idle, 1 move, 2 dwell; dwell_left counts ticks still to sit out.
  int  m_mode;
  int  m_x;
  int  m_s;
  int  m_dwell_left;
  bit  m_moving;

  cam_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .enable(enable),
    .speed_in(speed_in), .direction_cam(direction_cam), .camX(camX), .camS(camS),
    .moving(moving), .at_edge(at_edge), .frame_tick(frame_tick)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) if (frame_tick) tick_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 40; m_s = 1; m_dwell_left = 0; m_moving = 0;
  endtask

  task automatic model_tick(input bit en, input int spd, input logic [1:0] dir);
    int nx;
    m_s = (spd < 1) ? 1 : ((spd > 16) ? 16 : spd);
    if (m_mode == 0) begin
      m_moving = 0;
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!en) begin
        m_mode = 0; m_moving = 0;
      end else if (dir == 2'b10 || dir == 2'b11) begin
        m_moving = 0;
      end else begin
        if (dir == 2'b00) nx = (m_x - m_s < 10) ? 10 : m_x - m_s;
        else              nx = (m_x + m_s > 639) ? 639 : m_x + m_s;
        m_moving = (nx != m_x);
        m_x = nx;
        if (m_x == 10 || m_x == 639) begin
          m_mode = 2; m_dwell_left = 4;
        end
      end
    end else begin
      m_moving = 0;
      if (!en) m_mode = 0;
      else begin
        m_dwell_left--;
        if (m_dwell_left == 0) m_mode = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_camX"}, int'(camX), m_x);
    chk({tag, "_camS"}, int'(camS), m_s);
    chk({tag, "_moving"}, int'(moving), int'(m_moving));
    chk({tag, "_at_edge"}, int'(at_edge), (m_x == 10 || m_x == 639) ? 1 : 0);
  endtask

  // One frame: inputs settle, frame_clk rises between edges, update lands on the 3rd rising edge.
  task automatic do_frame(input bit en, input int spd, input logic [1:0] dir);
    int prev_x;
    prev_x = m_x;
    @(negedge Clk);
    enable = en; speed_in = 10'(spd); direction_cam = dir;
    #3 frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 chk("camX_before_3rd_edge", int'(camX), prev_x);
    @(posedge Clk);
    #1;
    model_tick(en, spd, dir);
    nfr++;
    check_outputs("frame");
    chk("tick_count", tick_cnt, nfr);
    @(negedge Clk);
    enable = 1'($urandom); speed_in = 10'($urandom); direction_cam = 2'($urandom);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; enable = 1'b0; speed_in = '0; direction_cam = 2'b10;
    model_reset();
    #25 frame_clk = 1'b1;
    #20 frame_clk = 1'b0;
    #25 Reset_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    chk("rst_camX", int'(camX), 40);
    chk("rst_camS", int'(camS), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_at_edge", int'(at_edge), 0);
    chk("rst_no_tick", tick_cnt, 0);

    // Walk left to the edge at speed 5.
    for (int i = 0; i < 7; i++) do_frame(1'b1, 5, 2'b00);
    chk("left_final", int'(camX), 10);
    chk("left_edge", int'(at_edge), 1);

    // Dwell four ticks, then leave to the right.
    for (int i = 0; i < 4; i++) do_frame(1'b1, 5, 2'b01);
    chk("dwell_hold", int'(camX), 10);
    do_frame(1'b1, 5, 2'b01);
    chk("dwell_exit", int'(camX), 15);

    // Approach 636, then saturate at 639.
    for (int i = 0; i < 60 && m_x + 16 <= 636; i++) do_frame(1'b1, 16, 2'b01);
    if (m_x < 636) do_frame(1'b1, 636 - m_x, 2'b01);
    chk("at_636", int'(camX), 636);
    do_frame(1'b1, 5, 2'b01);
    chk("sat_639", int'(camX), 639);
    chk("sat_edge", int'(at_edge), 1);

    // Finish dwell, then stop codes, then disable.
    for (int i = 0; i < 4; i++) do_frame(1'b1, 3, 2'b01);
    do_frame(1'b1, 7, 2'b10);
    do_frame(1'b1, 7, 2'b11);
    chk("stop_hold", int'(camX), 639);
    do_frame(1'b1, 7, 2'b00);
    chk("resume_left", int'(camX), 632);
    do_frame(1'b0, 7, 2'b00);
    do_frame(1'b0, 7, 2'b00);
    chk("idle_frozen", int'(camX), 632);

    // Back down to the left edge, then reset mid-dwell between clock edges.
    for (int i = 0; i < 100 && !(m_mode == 2); i++) do_frame(1'b1, 16, 2'b00);
    do_frame(1'b1, 16, 2'b01);
    @(posedge Clk);
    #5 Reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_camX", int'(camX), 40);
    chk("mid_rst_camS", int'(camS), 1);
    chk("mid_rst_moving", int'(moving), 0);
    chk("mid_rst_tick", int'(frame_tick), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);

    // Randomised frames.
    for (int i = 0; i < 300; i++)
      do_frame($urandom_range(0, 9) != 0, int'($urandom_range(0, 40)), 2'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_motion.md
Name: cam_motion

Overview:
- Camera position integrator that sits directly upstream and downstream of camera_control in a closed loop.
- Consumes direction_cam (00 left, 01 right, 10 stop) and produces the registered camX position and camS step that camera_control evaluates.
- Updates once per video frame, saturates at the screen limits and dwells at an edge before resuming motion.
- Instantiated in the top level beside the VGA controller; frame_clk is the VGA vsync.

Parameters:
- X_MIN, 10, leftmost legal camX.
- X_MAX, 639, rightmost legal camX.
- X_INIT, 40, camX after reset.
- DWELL_FRAMES, 4, frame ticks held at an edge before motion resumes; legal range 1..255.
- S_MAX, 16, upper clamp for camS.

Ports:
- Clk, input, 1, system clock (50 MHz).
- Reset_n, input, 1, asynchronous active-low reset.
- frame_clk, input, 1, vsync; asynchronous to Clk.
- enable, input, 1, motion enable, sampled on the frame tick.
- speed_in, input, 10, requested step per frame.
- direction_cam, input, 2, 00 left, 01 right, 10 stop, 11 treated as stop.
- camX, output, 10, registered camera X position.
- camS, output, 10, registered step size.
- moving, output, 1, high in MOVE when camX changed on the last tick.
- at_edge, output, 1, high while camX equals X_MIN or X_MAX.
- frame_tick, output, 1, one-Clk pulse per frame_clk rising edge (debug).

Behaviour:
- Reset (Reset_n low, async): camX=X_INIT, camS=1, state=IDLE, dwell_cnt=0, moving=0, at_edge=0, sync flops=0, frame_tick=0.
- Synchronisation: two-flop synchroniser (s1, s2) plus a delay flop s3; frame_tick = s2 & ~s3.
- All state and output updates occur only on Clk edges where frame_tick=1. Latency: camX changes on the 3rd Clk rising edge after frame_clk rises.
- camS on each tick = speed_in clamped to [1, S_MAX]; a speed_in of 0 yields 1.
- Arithmetic uses 11-bit intermediates:
  - left: next = camX - camS; if camX < X_MIN + camS, next = X_MIN.
  - right: next = camX + camS; if next > X_MAX, next = X_MAX.
  - No wrap-around ever occurs.
- FSM:
  - IDLE: hold camX. Go to MOVE on a tick with enable=1.
  - MOVE:
    - enable=0 on a tick: go to IDLE and hold camX.
    - direction stop or 11: hold camX, moving=0.
    - otherwise apply the step; moving=1 if camX changed.
    - If the new camX equals X_MIN or X_MAX: go to DWELL and load dwell_cnt=DWELL_FRAMES-1.
  - DWELL: hold camX, moving=0. Decrement dwell_cnt on each tick. On a tick with dwell_cnt=0, go to MOVE. enable=0 has priority and goes to IDLE.
- Edge exit:
  - On the first MOVE tick after DWELL, direction_cam (already flipped by camera_control) is applied normally.
  - If direction still points into the edge, camX saturates again and DWELL re-enters.
- at_edge is combinational from registered camX.
- Simultaneous events:
  - Reset overrides everything.
  - A frame_clk edge during reset is discarded.
  - A reset mid-DWELL returns to IDLE with X_INIT.
- Inputs are sampled only on the tick cycle; changes between ticks have no effect.

Optional Feature:
- Macro: CAM_MOTION_ACCEL_EN.
- Defined:
  - camS starts at 1 and increments by 1 per MOVE tick up to min(speed_in, S_MAX).
  - camS resets to 1 on a direction change, on DWELL exit and on IDLE entry.
  - The step applied on a tick uses camS from before the increment.
- Undefined: camS = clamped speed_in every tick, as above.

Test Plan:
- Reset then release, frame_clk idle -> camX=40, camS=1, moving=0, at_edge=0, frame_tick never pulses.
- enable=1, speed_in=5, dir=00, 7 frames from camX=40 -> 40 to 35, 30, 25, 20, 15 and 10 (FSM enters DWELL), then held at 10; at_edge=1; each update on the 3rd Clk edge after frame_clk rise.
- In DWELL at 10 with DWELL_FRAMES=4, dir=01 -> camX held for 4 ticks, then 15 on the 5th tick.
- camX=636, speed_in=5, dir=01 -> camX=639 (saturated, no wrap), DWELL entered.
- dir=10 and dir=11 on ticks -> camX unchanged, moving=0; enable=0 mid-MOVE -> IDLE, camX frozen.
- Reset_n pulsed low mid-DWELL between Clk edges -> outputs immediately at reset values.
- With CAM_MOTION_ACCEL_EN defined, speed_in=4, dir=01 from camX=40 -> camX 41, 43, 46, 50, 54.
